// File: rtl/mpic_prio_ctrl_if.sv
// Wishbone slave bus bundle for the priority interrupt controller.
// The member names match the controller's register-bus pins.
interface mpic_prio_ctrl_if;
    logic [1:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    // Bus master side (CPU / testbench)
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    // Controller side
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/mpic_prio_ctrl.sv
// Five-source fixed-priority interrupt controller with nesting.
// Bit 0 is the highest priority. A source may interrupt only while no
// in-service source of equal or higher priority exists. Registers:
// adr0 MASK, adr1 STATUS, adr2 EOI (write-only), adr3 VECTOR.
module mpic_prio_ctrl (
    input  logic                   clk_i,
    input  logic                   rst_i,
    mpic_prio_ctrl_if.slave        wb,
    input  logic [4:0]             pend_i,
    output logic [4:0]             clr_o,
    output logic                   irq_o,
    input  logic                   iack_i,
    output logic [2:0]             vec_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [2:0] VEC_SPURIOUS = 3'd7;

    state_t      state_q, state_d;
    logic [4:0]  mask_q, mask_d;
    logic [4:0]  isr_q, isr_d;
    logic [2:0]  vec_q, vec_d;
    logic        vv_q, vv_d;
    logic        ack_q, ack_d;

    logic [4:0]  elig;
    logic        any_elig;
    logic [2:0]  win;
    logic [4:0]  isr_low;
    logic        wr_en;
    logic        unused_bits;

    // Write qualifier: first cycle of a strobed write with lane 0 enabled
    assign wr_en = wb.wb_stb_i & wb.wb_cyc_i & wb.wb_we_i & wb.wb_sel_i[0] & ~ack_q;

    // One-hot of the lowest (highest-priority) in-service bit, cleared by EOI
    assign isr_low = isr_q & (~isr_q + 5'd1);

    assign unused_bits = &{1'b0, wb.wb_dat_i[15:5], wb.wb_sel_i[1]};

    // Eligibility: unmasked, pending and strictly above every in-service level
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        elig    = '0;
        for (int n = 0; n < 5; n++) begin
            blocked = blocked | isr_q[n];
            elig[n] = pend_i[n] & ~mask_q[n] & ~blocked;
        end
    end

    // Winner: lowest-index eligible source
    always_comb begin
        win      = 3'd0;
        any_elig = |elig;
        for (int n = 4; n >= 0; n--) begin
            if (elig[n]) win = 3'(n);
        end
    end

    // FSM next state, register updates and CPU-side outputs
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        isr_d   = isr_q;
        vec_d   = vec_q;
        vv_d    = vv_q;
        ack_d   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
        irq_o   = 1'b0;
        clr_o   = '0;
        vec_o   = vec_q;

        if (wr_en && wb.wb_adr_i == 2'd0) mask_d = wb.wb_dat_i[4:0];
        // EOI clear is based on the pre-edge ISR; an iack set below overrides it
        if (wr_en && wb.wb_adr_i == 2'd2) isr_d = isr_q & ~isr_low;

        case (state_q)
            S_IDLE: begin
                if (iack_i) begin
                    vec_d = VEC_SPURIOUS;
                    vv_d  = 1'b0;
                end
                if (any_elig) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                irq_o = 1'b1;
                vec_o = win;
                if (!any_elig) begin
                    state_d = S_IDLE;
                end else if (iack_i) begin
                    state_d = S_ACK;
                    isr_d   = isr_d | (5'd1 << win);
                    vec_d   = win;
                    vv_d    = 1'b1;
                end
            end
            S_ACK: begin
                clr_o   = 5'd1 << vec_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-data mux; unused bits read as zero
    always_comb begin
        wb.wb_dat_o = '0;
        case (wb.wb_adr_i)
            2'd0: wb.wb_dat_o[4:0] = mask_q;
            2'd1: begin
                wb.wb_dat_o[4:0]  = pend_i & ~mask_q;
                wb.wb_dat_o[12:8] = isr_q;
            end
            2'd3: begin
                wb.wb_dat_o[15]  = vv_q;
                wb.wb_dat_o[2:0] = vec_q;
            end
            default: wb.wb_dat_o = '0;
        endcase
    end

    assign wb.wb_ack_o = ack_q;

    // State and register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mask_q  <= 5'h1F;
            isr_q   <= '0;
            vec_q   <= VEC_SPURIOUS;
            vv_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            isr_q   <= isr_d;
            vec_q   <= vec_d;
            vv_q    <= vv_d;
            ack_q   <= ack_d;
        end
    end

endmodule

// File: tb/tb_mpic_prio_ctrl.sv
// Directed testbench for mpic_prio_ctrl.
module tb_mpic_prio_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] pend = '0;
    logic [4:0] clr;
    logic       irq;
    logic       iack = 1'b0;
    logic [2:0] vec;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] rd;

    mpic_prio_ctrl_if bus ();

    mpic_prio_ctrl dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .wb     (bus),
        .pend_i (pend),
        .clr_o  (clr),
        .irq_o  (irq),
        .iack_i (iack),
        .vec_o  (vec)
    );

    always #5 clk = ~clk;

    initial begin
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    end

    task automatic wb_write(input logic [1:0] adr, input logic [15:0] dat);
        @(negedge clk);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = 2'b01;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(negedge clk);
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_sel_i = 2'b00;
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [15:0] dat);
        @(negedge clk);
        bus.wb_adr_i = adr;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(negedge clk);
        dat = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++; if (clr !== 5'b0) begin errors++; $display("FAIL reset_clr got %b exp 00000", clr); end
        checks++; if (vec !== 3'd7) begin errors++; $display("FAIL reset_vec got %0d exp 7", vec); end
        checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", bus.wb_ack_o); end
        wb_read(2'd0, rd);
        checks++; if (rd !== 16'h001F) begin errors++; $display("FAIL reset_mask got %h exp 001f", rd); end
        wb_read(2'd3, rd);
        checks++; if (rd !== 16'h0007) begin errors++; $display("FAIL reset_vector got %h exp 0007", rd); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL reset_status got %h exp 0000", rd); end
    endtask

    task automatic test_basic();
        wb_write(2'd0, 16'h0000);
        pend = 5'b10100;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got %b exp 1", irq); end
        checks++; if (vec !== 3'd2) begin errors++; $display("FAIL basic_vec got %0d exp 2", vec); end
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        checks++; if (clr !== 5'b00100) begin errors++; $display("FAIL basic_clr got %b exp 00100", clr); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_ack got %b exp 0", irq); end
        pend = 5'b10000;
        @(negedge clk);
        checks++; if (clr !== 5'b0) begin errors++; $display("FAIL basic_clr_once got %b exp 00000", clr); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 16'h0410) begin errors++; $display("FAIL basic_status got %h exp 0410", rd); end
    endtask

    task automatic test_preempt();
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL preempt_low_blocked got %b exp 0", irq); end
        pend = 5'b00001;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL preempt_irq got %b exp 1", irq); end
        checks++; if (vec !== 3'd0) begin errors++; $display("FAIL preempt_vec got %0d exp 0", vec); end
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        checks++; if (clr !== 5'b00001) begin errors++; $display("FAIL preempt_clr got %b exp 00001", clr); end
        pend = 5'b00000;
        @(negedge clk);
        wb_read(2'd1, rd);
        checks++; if (rd !== 16'h0500) begin errors++; $display("FAIL preempt_isr got %h exp 0500", rd); end
        wb_write(2'd2, 16'hFFFF);
        wb_read(2'd1, rd);
        checks++; if (rd !== 16'h0400) begin errors++; $display("FAIL preempt_eoi got %h exp 0400", rd); end
        wb_read(2'd2, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL eoi_read got %h exp 0000", rd); end
    endtask

    task automatic test_mask_withdraw();
        wb_write(2'd2, 16'h0000);
        wb_read(2'd3, rd);
        checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL withdraw_vector_pre got %h exp 8000", rd); end
        pend = 5'b01000;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL withdraw_irq got %b exp 1", irq); end
        checks++; if (vec !== 3'd3) begin errors++; $display("FAIL withdraw_vec got %0d exp 3", vec); end
        wb_write(2'd0, 16'h0008);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL withdraw_irq_drop got %b exp 0", irq); end
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        wb_read(2'd3, rd);
        checks++; if (rd !== 16'h0007) begin errors++; $display("FAIL spurious_vector got %h exp 0007", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL spurious_irq got %b exp 0", irq); end
        pend = 5'b00000;
    endtask

    task automatic test_eoi_iack();
        wb_write(2'd0, 16'h0000);
        pend = 5'b00010;
        @(negedge clk);
        checks++; if (vec !== 3'd1) begin errors++; $display("FAIL eoiack_vec1 got %0d exp 1", vec); end
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        pend = 5'b00000;
        @(negedge clk);
        pend = 5'b00001;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL eoiack_irq got %b exp 1", irq); end
        checks++; if (vec !== 3'd0) begin errors++; $display("FAIL eoiack_vec0 got %0d exp 0", vec); end
        bus.wb_adr_i = 2'd2;
        bus.wb_dat_i = 16'h0000;
        bus.wb_sel_i = 2'b01;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_sel_i = 2'b00;
        pend = 5'b00000;
        wb_read(2'd1, rd);
        checks++; if (rd !== 16'h0100) begin errors++; $display("FAIL eoiack_isr got %h exp 0100", rd); end
    endtask

    task automatic test_reset_in_ack();
        wb_write(2'd2, 16'h0000);
        pend = 5'b00100;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstack_irq got %b exp 1", irq); end
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        checks++; if (clr !== 5'b00100) begin errors++; $display("FAIL rstack_clr_pre got %b exp 00100", clr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (clr !== 5'b0) begin errors++; $display("FAIL rstack_clr got %b exp 00000", clr); end
        checks++; if (vec !== 3'd7) begin errors++; $display("FAIL rstack_vec got %0d exp 7", vec); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstack_status got %h exp 0000", rd); end
        wb_read(2'd0, rd);
        checks++; if (rd !== 16'h001F) begin errors++; $display("FAIL rstack_mask got %h exp 001f", rd); end
        pend = 5'b00000;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.wb_adr_i = 2'd0;
        bus.wb_sel_i = 2'b01;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wb_dat_i = 16'(i + 1);
            checks++;
            if (bus.wb_ack_o !== 1'(i % 2)) begin
                errors++;
                $display("FAIL b2b_ack cycle %0d got %b exp %0d", i, bus.wb_ack_o, i % 2);
            end
            @(negedge clk);
        end
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        wb_read(2'd0, rd);
        checks++; if (rd !== 16'h0003) begin errors++; $display("FAIL b2b_writes got %h exp 0003", rd); end
        @(negedge clk);
        bus.wb_adr_i = 2'd0;
        bus.wb_dat_i = 16'h001F;
        bus.wb_sel_i = 2'b10;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(negedge clk);
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_sel_i = 2'b00;
        wb_read(2'd0, rd);
        checks++; if (rd !== 16'h0003) begin errors++; $display("FAIL sel_lane1_write got %h exp 0003", rd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_preempt();
        test_mask_withdraw();
        test_eoi_iack();
        test_reset_in_ack();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
